// File: rtl/uart_tx_sched_if.sv
// Bundle for uart_tx_sched: four requester byte streams in, one UART TX core
// out, plus clear-to-send and status.
interface uart_tx_sched_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        cts_n;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    modport master (
        output req_valid, req_data, req_last, tx_done, cts_n,
        input  req_ready, tx_data, tx_start, grant_id, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done, cts_n,
        output req_ready, tx_data, tx_start, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler sharing one UART transmitter among four requesters,
// with packet locking, inter-frame gap and a per-frame watchdog.
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 131072
) (
    input logic           clk,
    input logic           rst,
    uart_tx_sched_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for cts and an eligible requester; handshake happens here
    // START | one-cycle tx_start pulse to the TX core
    // WAIT  | frame in flight, watchdog running
    // GAP   | enforced idle time between frames
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]       state;
    logic [7:0]       tx_data_q;
    logic [1:0]       grant_q;
    logic             lock;
    logic [1:0]       rr_ptr;
    logic [TMR_W-1:0] timer;
    logic [GAP_W-1:0] gap_cnt;

    logic [3:0] elig;
    logic [1:0] win;
    logic [1:0] cand;
    logic       win_vld;
    logic       handshake;

    // While a packet is open only its owner may be picked, even if it is idle.
    always_comb begin
        if (lock) begin
            elig = bus.req_valid & (4'b0001 << grant_q);
        end else begin
            elig = bus.req_valid;
        end
    end

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = rr_ptr + 2'(k);
            if (!win_vld && elig[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign handshake = (state == S_IDLE) && !rst && !bus.cts_n && win_vld;

    assign bus.req_ready   = handshake ? (4'b0001 << win) : 4'b0000;
    assign bus.tx_start    = (state == S_START);
    assign bus.busy        = (state != S_IDLE);
    assign bus.timeout_err = (state == S_WAIT) && !bus.tx_done && (timer == TMR_LAST);
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_data_q <= '0;
            grant_q   <= '0;
            lock      <= 1'b0;
            rr_ptr    <= 2'd3;
            timer     <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        tx_data_q <= bus.req_data[{win, 3'b000} +: 8];
                        grant_q   <= win;
                        lock      <= ~bus.req_last[win];
                        rr_ptr    <= win;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the final watchdog cycle still counts as success.
                    if (bus.tx_done) begin
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end
                    end else if (timer == TMR_LAST) begin
                        lock  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: per-requester byte queues plus a
// transaction-level arbitration model predict every handshake and frame.
module tb_uart_tx_sched;
    localparam int GAP = 16;
    localparam int TO  = 40;

    logic clk;
    logic rst;
    uart_tx_sched_if ifc ();

    uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ent_t;

    ent_t q[4][$];
    int   got[$];
    int   errors = 0;
    int   checks = 0;
    bit   cts_rand = 0;

    bit   m_lock;
    int   m_lock_id;
    int   m_rr;

    logic [3:0] s_ready;
    logic       s_start;
    logic [7:0] s_data;
    logic [1:0] s_grant;
    logic       s_busy;
    logic       s_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester to serve next: owner of an open packet, else first pending after the last winner.
    function automatic int model_winner();
        if (m_lock) return (q[m_lock_id].size() > 0) ? m_lock_id : -1;
        for (int k = 1; k <= 4; k++) begin
            if (q[(m_rr + k) % 4].size() > 0) return (m_rr + k) % 4;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            ifc.req_valid[i] = (q[i].size() > 0);
            if (q[i].size() > 0) begin
                ifc.req_data[8*i +: 8] = q[i][0].d;
                ifc.req_last[i]        = q[i][0].l;
            end else begin
                ifc.req_data[8*i +: 8] = 8'($urandom);
                ifc.req_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        ent_t e;
        e.d = d;
        e.l = l;
        q[r].push_back(e);
    endtask

    task automatic sample();
        @(negedge clk);
        s_ready = ifc.req_ready;
        s_start = ifc.tx_start;
        s_data  = ifc.tx_data;
        s_grant = ifc.grant_id;
        s_busy  = ifc.busy;
        s_to    = ifc.timeout_err;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (s_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
        s_ready = '0;
        ifc.tx_done = 1'b0;
        if (cts_rand) ifc.cts_n = ($urandom_range(0, 3) == 0);
        drive();
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) q[i].delete();
        m_lock    = 0;
        m_lock_id = 0;
        m_rr      = 3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ifc.req_valid = 4'hF;
        ifc.cts_n     = 1'b0;
        ifc.tx_done   = 1'b0;
        #1;
        check("rst_ready", ifc.req_ready, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_start", ifc.tx_start, 0);
        check("rst_data", ifc.tx_data, 0);
        check("rst_grant", ifc.grant_id, 0);
        check("rst_timeout", ifc.timeout_err, 0);
        @(posedge clk);
        #1;
        check("rst_ready_hold", ifc.req_ready, 0);
        rst = 1'b0;
        s_ready = '0;
        model_clear();
        drive();
    endtask

    task automatic idle_check(input int n);
        int w;
        logic [31:0] e;
        for (int c = 0; c < n; c++) begin
            sample();
            w = ifc.cts_n ? -1 : model_winner();
            e = '0;
            if (w >= 0) e[w] = 1'b1;
            check("idle_ready", s_ready, e);
            check("idle_busy", s_busy, 0);
            check("idle_start", s_start, 0);
            adv();
        end
    endtask

    // d>0: tx_done in WAIT cycle d; d=0: never (watchdog); d<0: reset hit in WAIT.
    task automatic frame(input int d, input bit cts_wait);
        int w;
        bit hs;
        logic [7:0] eb;
        logic [31:0] e;
        hs = 0;
        w  = -1;
        eb = '0;
        for (int n = 0; n < 200 && !hs; n++) begin
            sample();
            w = ifc.cts_n ? -1 : model_winner();
            e = '0;
            if (w >= 0) e[w] = 1'b1;
            check("hs_busy", s_busy, 0);
            check("hs_ready", s_ready, e);
            hs = (w >= 0) || (s_ready != 0);
            if (w >= 0) begin
                eb        = q[w][0].d;
                m_lock    = !q[w][0].l;
                m_lock_id = w;
                m_rr      = w;
            end
            adv();
        end
        check("hs_seen", 32'(hs), 1);
        if (!hs || w < 0) return;

        sample();
        check("start_pulse", s_start, 1);
        check("start_data", s_data, eb);
        check("start_grant", s_grant, w);
        check("start_ready", s_ready, 0);
        check("start_busy", s_busy, 1);
        got.push_back(int'(s_grant));
        adv();

        for (int i = 1; i <= TO; i++) begin
            if (i == d) ifc.tx_done = 1'b1;
            if (cts_wait && i == 1) ifc.cts_n = 1'b1;
            if (d < 0 && i == 3) begin
                #2;
                rst = 1'b1;
                #1;
                check("arst_busy", ifc.busy, 0);
                check("arst_data", ifc.tx_data, 0);
                check("arst_grant", ifc.grant_id, 0);
                check("arst_start", ifc.tx_start, 0);
                check("arst_timeout", ifc.timeout_err, 0);
                check("arst_ready", ifc.req_ready, 0);
                return;
            end
            sample();
            check("wait_start", s_start, 0);
            check("wait_busy", s_busy, 1);
            check("wait_ready", s_ready, 0);
            check("wait_timeout", s_to, (i == TO && i != d) ? 1 : 0);
            adv();
            if (i == d) break;
            if (i == TO) begin
                m_lock = 0;
                return;
            end
        end

        for (int g = 1; g <= GAP; g++) begin
            if ($urandom_range(0, 7) == 0) ifc.tx_done = 1'b1;
            sample();
            check("gap_busy", s_busy, 1);
            check("gap_ready", s_ready, 0);
            check("gap_start", s_start, 0);
            check("gap_timeout", s_to, 0);
            adv();
        end
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(tag, got[i], exp[i]);
    endtask

    initial begin
        int r, len, iter;
        bit pending;
        rst = 1'b1;
        ifc.req_valid = '0;
        ifc.req_data  = '0;
        ifc.req_last  = '0;
        ifc.tx_done   = 1'b0;
        ifc.cts_n     = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        do_reset();

        // single byte from requester 2, full gap afterwards
        push(2, 8'hA5, 1'b1);
        drive();
        got.delete();
        frame(5, 0);
        check_order("single_grant", '{2});
        idle_check(2);

        // three continuously valid requesters rotate fairly
        do_reset();
        got.delete();
        for (int k = 0; k < 2; k++) begin
            push(0, 8'($urandom), 1'b1);
            push(1, 8'($urandom), 1'b1);
            push(3, 8'($urandom), 1'b1);
        end
        drive();
        for (int k = 0; k < 6; k++) frame($urandom_range(1, 10), 0);
        check_order("rr_order", '{0, 1, 3, 0, 1, 3});

        // open packet on requester 1 holds off requester 0
        do_reset();
        got.delete();
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b0);
        push(1, 8'h13, 1'b1);
        drive();
        frame(4, 0);
        push(0, 8'h01, 1'b1);
        drive();
        for (int k = 0; k < 3; k++) frame($urandom_range(1, 10), 0);
        check_order("lock_order", '{1, 1, 1, 0});

        // clear-to-send gating and cts ignored once a frame is under way
        ifc.cts_n = 1'b1;
        push(3, 8'h3C, 1'b1);
        drive();
        idle_check(8);
        ifc.cts_n = 1'b0;
        frame(6, 1);
        ifc.cts_n = 1'b0;

        // lock persists across an idle owner, watchdog clears it, done wins on the last cycle
        do_reset();
        got.delete();
        push(0, 8'hB0, 1'b0);
        push(1, 8'hC1, 1'b1);
        drive();
        frame(3, 0);
        idle_check(6);
        push(0, 8'hB1, 1'b0);
        drive();
        frame(0, 0);
        frame(3, 0);
        push(2, 8'hD2, 1'b1);
        drive();
        frame(TO, 0);
        check_order("timeout_order", '{0, 0, 1, 2});

        // randomized packets with cts noise and occasional watchdog expiry
        do_reset();
        cts_rand = 1;
        for (int round = 0; round < 3; round++) begin
            for (int p = 0; p < 5; p++) begin
                r   = $urandom_range(0, 3);
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) push(r, 8'($urandom), (b == len - 1));
            end
            drive();
            iter = 0;
            pending = 1;
            while (pending && iter < 60) begin
                if ($urandom_range(0, 9) == 0) frame(0, 0);
                else frame($urandom_range(1, 12), 0);
                iter++;
                pending = 0;
                for (int i = 0; i < 4; i++) if (q[i].size() > 0) pending = 1;
            end
            check("rand_drained", 32'(pending), 0);
        end
        cts_rand = 0;
        ifc.cts_n = 1'b0;

        // reset in the middle of WAIT, later tx_done must not wake anything
        do_reset();
        push(0, 8'h5A, 1'b1);
        drive();
        frame(-1, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        ifc.tx_done = 1'b1;
        idle_check(1);
        idle_check(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the UART transmitter (fixed at 4 for this revision).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, idle clk cycles enforced between frames.
REQ-003 SHALL have parameter TIMEOUT, default 131072, max clk cycles from tx_start to tx_done before abort.
REQ-004 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 4, per-requester byte available.
REQ-007 SHALL have port req_data, input, 32, packed bytes; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port req_last, input, 4, per-requester last byte of packet, qualified by req_valid.
REQ-009 SHALL have port req_ready, output, 4, one-hot byte-accept strobe.
REQ-010 SHALL have port tx_data, output, 8, byte presented to the UART TX core.
REQ-011 SHALL have port tx_start, output, 1, one-cycle frame start pulse to the TX core.
REQ-012 SHALL have port tx_done, input, 1, one-cycle frame complete pulse from the TX core.
REQ-013 SHALL have port cts_n, input, 1, active-low clear-to-send, already synchronised.
REQ-014 SHALL have port grant_id, output, 2, index of the requester owning the current or last frame.
REQ-015 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-016 SHALL have port timeout_err, output, 1, one-cycle pulse on frame abort.

Function
REQ-017 SHALL implement the FSM states IDLE, START, WAIT and GAP.
REQ-018 In IDLE with cts_n=0 and an eligible valid requester: select winner w, assert req_ready[w] combinationally in that cycle, register tx_data<=req_data[w], grant_id<=w, lock<=~req_last[w], rr_ptr<=w, and go to START.
REQ-019 Eligibility: if lock=1, only the locked requester (grant_id) is eligible and all others are ignored; if lock=0, round-robin applies, searching from rr_ptr+1 modulo 4.
REQ-020 In IDLE with cts_n=1, or with no eligible valid, req_ready SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-021 START: tx_start=1 for exactly one cycle, timer cleared to 0, next state WAIT.
REQ-022 Latency: handshake in cycle n gives tx_start in cycle n+1.
REQ-023 WAIT: the timer increments each cycle; on tx_done the FSM goes to GAP, or to IDLE if GAP_CYCLES=0.
REQ-024 WAIT: when the timer reaches TIMEOUT-1 without tx_done, the block pulses timeout_err, clears lock and goes to IDLE.
REQ-025 If tx_done and the timeout coincide, tx_done wins and timeout_err stays 0.
REQ-026 GAP: the block counts GAP_CYCLES cycles, then goes to IDLE.
REQ-027 tx_done outside WAIT SHALL be ignored.
REQ-028 cts_n SHALL be sampled only in IDLE; deassertion during START/WAIT/GAP does not abort the frame.
REQ-029 req_ready SHALL be 0 in every state except IDLE.
REQ-030 tx_data and grant_id SHALL hold their values until the next handshake.
REQ-031 If the locked requester drops req_valid, lock SHALL persist and no other requester is served until its next byte or a timeout.

Reset
REQ-032 While rst=1: state=IDLE, req_ready=0, tx_data=0, tx_start=0, grant_id=0, busy=0, timeout_err=0, lock=0, rr_ptr=3 (requester 0 highest priority first), timer=0, gap counter=0.
REQ-033 Asserting rst mid-frame SHALL abandon the frame immediately with no timeout_err; after release the block starts in IDLE.

Verification
REQ-034 Single byte, requester 2, req_data byte 0xA5, last=1 -> req_ready=4'b0100 in cycle n; tx_start and tx_data=0xA5 in n+1; grant_id=2; after tx_done, busy stays high 16 cycles.
REQ-035 Requesters 0,1,3 valid continuously with last=1 -> grant order 0,1,3,0,1,3; no requester is served twice before another pending one.
REQ-036 Requester 1 sends a 3-byte packet (last only on byte 3) while requester 0 is valid -> bytes 1,1,1 are sent before requester 0 is granted.
REQ-037 cts_n=1 with valid pending -> no req_ready and no tx_start; cts_n falls -> handshake in the same cycle; cts_n rising during WAIT does not affect the frame.
REQ-038 tx_done withheld -> timeout_err pulses exactly TIMEOUT cycles after tx_start, lock clears, and the next requester is served.
REQ-039 rst asserted in WAIT -> all outputs return to reset values asynchronously; a later tx_done pulse causes no transition.
